// File: rtl/mcu_sci_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mcu_sci_fifo
// Purpose  : Serial communication interface for the MCU internal bus with
//            generic bit rate and data width, RX FIFO, false-start rejection,
//            framing/overrun flags and a threshold-based RX interrupt.
// Ports    : mcu_clx2 core clock, mcu_rst_n synchronous active-low reset,
//            mcu_ad/mcu_wr/mcu_do bus address/strobe/write data,
//            rx serial in, tx serial out, te transmitter enable,
//            irq2 interrupt request, en_sci window hit, iod read data.
// Options  : define MCU_SCI_PARITY_EN to add the parity bit (CTRL[5:4]).
// Revision : 1.0 - initial release
// ============================================================================
module mcu_sci_fifo #(
    parameter logic [15:0] BASE_AD   = 16'h0010,
    parameter int          CLK_DIV   = 256,
    parameter int          DATA_BITS = 8,
    parameter int          RX_DEPTH  = 4,
    parameter int          RX_LEVEL  = 1
) (
    input  logic        mcu_clx2,
    input  logic        mcu_rst_n,
    input  logic [15:0] mcu_ad,
    input  logic        mcu_wr,
    input  logic [7:0]  mcu_do,
    input  logic        rx,
    output logic        tx,
    output logic        te,
    output logic        irq2,
    output logic        en_sci,
    output logic [7:0]  iod
);
    localparam int c_AW = $clog2(RX_DEPTH);
    localparam int c_CW = $clog2(CLK_DIV);
    localparam int c_BW = $clog2(DATA_BITS + 2);
    localparam logic [c_AW:0]   c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};
    localparam logic [c_CW-1:0] c_CNT_ONE = {{(c_CW-1){1'b0}}, 1'b1};
    localparam logic [c_BW-1:0] c_BIT_ONE = {{(c_BW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- bus decode ----------------
    logic [15:0] w_off16;
    logic [1:0]  w_off;
    logic        w_wr, w_rd, w_rd_ev, w_ctrl_wr, w_tdr_wr, w_st_ev, w_rdr_ev;
    logic        r_rd_prev;
    logic [1:0]  r_rd_off;

    assign w_off16 = mcu_ad - BASE_AD;
    assign en_sci  = (w_off16 < 16'd4);
    assign w_off   = w_off16[1:0];
    assign w_wr    = en_sci & mcu_wr;
    assign w_rd    = en_sci & ~mcu_wr;
    // Only the first cycle of a held read at one address counts as an event.
    assign w_rd_ev   = w_rd & ~(r_rd_prev & (r_rd_off == w_off));
    assign w_ctrl_wr = w_wr & (w_off == 2'd0);
    assign w_tdr_wr  = w_wr & (w_off == 2'd3);
    assign w_st_ev   = w_rd_ev & (w_off == 2'd1);
    assign w_rdr_ev  = w_rd_ev & (w_off == 2'd2);

    // ---------------- registers ----------------
    logic [5:0]           r_ctrl;
    logic [DATA_BITS-1:0] r_tdr;
    logic                 r_tdre, r_orfe, r_fe, r_pe, r_clr_rd, r_irq;
    logic                 w_pen, w_odd;

`ifdef MCU_SCI_PARITY_EN
    localparam logic [5:0] c_CTRL_MASK = 6'h3F;
    assign w_pen = r_ctrl[4];
    assign w_odd = r_ctrl[5];
`else
    localparam logic [5:0] c_CTRL_MASK = 6'h0F;
    assign w_pen = 1'b0;
    assign w_odd = 1'b0;
`endif

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] r_fifo [RX_DEPTH];
    logic [c_AW:0]        r_wr_ptr, r_rd_ptr, w_count;
    logic [31:0]          w_cnt_ext;
    logic                 w_empty, w_full, w_push, w_pop, w_push_ok, w_ovf, w_clr;
    logic [DATA_BITS-1:0] r_rx_sh;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_cnt_ext = 32'(w_count);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (w_cnt_ext == 32'(RX_DEPTH));
    assign w_pop     = w_rdr_ev & ~w_empty;
    // A full FIFO still accepts a byte when an entry leaves in the same cycle.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_ovf     = w_push & w_full & ~w_pop;
    assign w_clr     = w_rdr_ev & r_clr_rd;

    always_ff @(posedge mcu_clx2) begin
        if (w_push_ok) r_fifo[r_wr_ptr[c_AW-1:0]] <= r_rx_sh;
    end

    // ---------------- TX FSM ----------------
    tx_state_t             r_tx_state, w_tx_nx;
    logic [c_CW-1:0]       r_tx_cnt;
    logic [c_BW-1:0]       r_tx_bit, w_tx_last;
    logic [DATA_BITS:0]    r_tx_sh;
    logic                  r_tx, w_tx_end, w_tx_go, w_tx_load, w_tx_shift;

    assign w_tx_end  = (r_tx_cnt == c_CW'(CLK_DIV - 1));
    assign w_tx_go   = r_ctrl[0] & ~r_tdre;
    assign w_tx_last = c_BW'(DATA_BITS - 1) + {{(c_BW-1){1'b0}}, w_pen};

    always_comb begin
        w_tx_nx    = r_tx_state;
        w_tx_load  = 1'b0;
        w_tx_shift = 1'b0;
        unique case (r_tx_state)
            TX_IDLE:  if (w_tx_go) begin w_tx_nx = TX_START; w_tx_load = 1'b1; end
            TX_START: if (w_tx_end) begin w_tx_nx = TX_DATA; w_tx_shift = 1'b1; end
            TX_DATA:  if (w_tx_end) begin
                          if (r_tx_bit == w_tx_last) w_tx_nx = TX_STOP;
                          else                       w_tx_shift = 1'b1;
                      end
            TX_STOP:  if (w_tx_end) begin
                          // Chain straight into the next start bit if data waits.
                          if (w_tx_go) begin w_tx_nx = TX_START; w_tx_load = 1'b1; end
                          else               w_tx_nx = TX_IDLE;
                      end
            default:  w_tx_nx = TX_IDLE;
        endcase
    end

    // ---------------- RX FSM ----------------
    rx_state_t        r_rx_state, w_rx_nx;
    logic [c_CW-1:0]  r_rx_cnt;
    logic [c_BW-1:0]  r_rx_bit, w_rx_last;
    logic             r_rx_s1, r_rx_s2, r_rx_s3, r_rx_par;
    logic             w_rx_end, w_rx_sample, w_fe_set, w_pe_set;

    assign w_rx_end  = (r_rx_cnt == c_CW'(CLK_DIV - 1));
    assign w_rx_last = c_BW'(DATA_BITS - 1) + {{(c_BW-1){1'b0}}, w_pen};
    assign w_fe_set  = w_push & ~r_rx_s2;
    assign w_pe_set  = w_push & w_pen & (^r_rx_sh ^ r_rx_par ^ w_odd);

    always_comb begin
        w_rx_nx     = r_rx_state;
        w_rx_sample = 1'b0;
        w_push      = 1'b0;
        unique case (r_rx_state)
            RX_IDLE:  if (r_rx_s3 & ~r_rx_s2) w_rx_nx = RX_START;
            RX_START: if (r_rx_cnt == c_CW'(CLK_DIV / 2 - 1))
                          w_rx_nx = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_end) begin
                          w_rx_sample = 1'b1;
                          if (r_rx_bit == w_rx_last) w_rx_nx = RX_STOP;
                      end
            RX_STOP:  if (w_rx_end) begin w_push = 1'b1; w_rx_nx = RX_IDLE; end
            default:  w_rx_nx = RX_IDLE;
        endcase
        if (!r_ctrl[2]) begin
            w_rx_nx     = RX_IDLE;
            w_rx_sample = 1'b0;
            w_push      = 1'b0;
        end
    end

    // ---------------- sequential state ----------------
    always_ff @(posedge mcu_clx2) begin
        if (!mcu_rst_n) begin
            r_ctrl     <= 6'h00;
            r_tdr      <= '0;
            r_tdre     <= 1'b1;
            r_orfe     <= 1'b0;
            r_fe       <= 1'b0;
            r_pe       <= 1'b0;
            r_clr_rd   <= 1'b0;
            r_irq      <= 1'b0;
            r_rd_prev  <= 1'b0;
            r_rd_off   <= 2'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '1;
            r_tx       <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
            r_rx_par   <= 1'b0;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
        end else begin
            r_rd_prev <= w_rd;
            r_rd_off  <= w_off;
            if (w_ctrl_wr) r_ctrl <= mcu_do[5:0] & c_CTRL_MASK;
            if (w_tdr_wr) begin
                r_tdr  <= mcu_do[DATA_BITS-1:0];
                r_tdre <= 1'b0;
            end else if (w_tx_load) begin
                r_tdre <= 1'b1;
            end

            // flags: a new event in the clearing cycle wins
            if (w_st_ev)   r_clr_rd <= 1'b1;
            else if (w_clr) r_clr_rd <= 1'b0;
            if (w_clr) begin
                r_orfe <= 1'b0;
                r_fe   <= 1'b0;
                r_pe   <= 1'b0;
            end
            if (w_ovf)    r_orfe <= 1'b1;
            if (w_fe_set) r_fe   <= 1'b1;
            if (w_pe_set) r_pe   <= 1'b1;

            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_ONE;

            r_irq <= (r_ctrl[3] & ((w_cnt_ext >= 32'(RX_LEVEL)) | r_orfe | r_fe | r_pe))
                   | (r_ctrl[1] & r_tdre);

            // transmitter
            r_tx_state <= w_tx_nx;
            r_tx_cnt   <= (r_tx_state == TX_IDLE || w_tx_end) ? '0 : r_tx_cnt + c_CNT_ONE;
            if (w_tx_load) begin
                r_tx     <= 1'b0;
                r_tx_sh  <= {^r_tdr ^ w_odd, r_tdr};
                r_tx_bit <= '0;
            end else if (w_tx_shift) begin
                r_tx     <= r_tx_sh[0];
                r_tx_sh  <= {1'b1, r_tx_sh[DATA_BITS:1]};
                if (r_tx_state == TX_DATA) r_tx_bit <= r_tx_bit + c_BIT_ONE;
            end else if (w_tx_nx == TX_STOP || w_tx_nx == TX_IDLE) begin
                r_tx <= 1'b1;
            end

            // receiver
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_state <= w_rx_nx;
            r_rx_cnt   <= (w_rx_nx != r_rx_state || w_rx_end) ? '0 : r_rx_cnt + c_CNT_ONE;
            if (r_rx_state != RX_DATA) begin
                r_rx_bit <= '0;
            end else if (w_rx_sample) begin
                r_rx_bit <= r_rx_bit + c_BIT_ONE;
                if (r_rx_bit < c_BW'(DATA_BITS)) r_rx_sh <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
                else                             r_rx_par <= r_rx_s2;
            end
        end
    end

    // ---------------- read mux ----------------
    logic [7:0] w_status;
`ifdef MCU_SCI_PARITY_EN
    assign w_status = {~w_empty, r_orfe, r_tdre, r_fe, r_pe,
                       (w_cnt_ext > 32'd7) ? 3'h7 : w_cnt_ext[2:0]};
`else
    assign w_status = {~w_empty, r_orfe, r_tdre, r_fe,
                       (w_cnt_ext > 32'd15) ? 4'hF : w_cnt_ext[3:0]};
`endif

    always_comb begin
        iod = 8'h00;
        if (en_sci) begin
            unique case (w_off)
                2'd0:    iod = {2'b00, r_ctrl};
                2'd1:    iod = w_status;
                2'd2:    iod = w_empty ? 8'h00 : 8'(r_fifo[r_rd_ptr[c_AW-1:0]]);
                default: iod = 8'h00;
            endcase
        end
    end

    assign tx   = r_tx;
    assign te   = r_ctrl[0];
    assign irq2 = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_mcu_sci_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_sci_fifo
// Purpose  : Self-checking bench for mcu_sci_fifo (CLK_DIV=16, RX_DEPTH=4,
//            RX_LEVEL=2): register table plus TX, RX, overrun, false-start,
//            framing, interrupt and mid-frame reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcu_sci_fifo;
    localparam int c_DIV = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ad;
    logic        wr;
    logic [7:0]  wdat;
    logic        rx;
    logic        tx, te, irq2, en_sci;
    logic [7:0]  iod;

    int errs   = 0;
    int checks = 0;

    mcu_sci_fifo #(
        .BASE_AD  (16'h0010),
        .CLK_DIV  (c_DIV),
        .DATA_BITS(8),
        .RX_DEPTH (4),
        .RX_LEVEL (2)
    ) dut (
        .mcu_clx2 (clk),
        .mcu_rst_n(rst_n),
        .mcu_ad   (ad),
        .mcu_wr   (wr),
        .mcu_do   (wdat),
        .rx       (rx),
        .tx       (tx),
        .te       (te),
        .irq2     (irq2),
        .en_sci   (en_sci),
        .iod      (iod)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        wr;
        logic [15:0] ad;
        logic [7:0]  d;
        logic [15:0] pk;
        logic [7:0]  exp_iod;
        logic        exp_en;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ad = 16'h0000; wr = 1'b0; wdat = 8'h00; rx = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    // combinational look at the bus without letting a clock edge see it
    task automatic peek(input logic [15:0] a, output logic [7:0] v, output logic e);
        ad = a; wr = 1'b0;
        #1;
        v = iod;
        e = en_sci;
        ad = 16'h0000;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        ad = a; wr = 1'b1; wdat = d;
        step();
        wr = 1'b0; ad = 16'h0000;
    endtask

    task automatic bus_read(input logic [15:0] a, input int n, output logic [7:0] v);
        ad = a; wr = 1'b0;
        #1;
        v = iod;
        repeat (n) step();
        ad = 16'h0000;
        step();
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (c_DIV) step();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (c_DIV) step();
        end
        rx = stop_bit;
        repeat (c_DIV) step();
        rx = 1'b1;
        repeat (4) step();
    endtask

    logic [7:0] v;
    logic       e;
    logic [9:0] frame;
    int         bad;
    logic       found;

    initial begin
        // wr, addr, data, peek addr, expected iod, en_sci, irq2
        tbl[0]  = '{1'b0, 16'h0000, 8'h00, 16'h0010, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 8'h00, 16'h0011, 8'h20, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 8'h00, 16'h0012, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 8'h00, 16'h0013, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 8'h00, 16'h0014, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 8'h00, 16'h000F, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 16'h0010, 8'hFF, 16'h0010, 8'h0F, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 16'h0014, 8'h00, 16'h0010, 8'h0F, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 16'h000F, 8'h00, 16'h0010, 8'h0F, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 16'h0010, 8'h02, 16'h0010, 8'h02, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 16'h0010, 8'h00, 16'h0010, 8'h00, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 16'h0011, 8'hFF, 16'h0011, 8'h20, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 16'h0012, 8'hFF, 16'h0012, 8'h00, 1'b1, 1'b0};

        do_reset();
        check("reset_tx", tx, 1'b1);
        check("reset_te", te, 1'b0);
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].ad, tbl[i].d);
            peek(tbl[i].pk, v, e);
            check($sformatf("tbl%0d_iod", i), v, tbl[i].exp_iod);
            check($sformatf("tbl%0d_en", i), e, tbl[i].exp_en);
            check($sformatf("tbl%0d_irq", i), irq2, tbl[i].exp_irq);
        end

        // ---- TX frame 0xA5 ----
        do_reset();
        bus_write(16'h0010, 8'h01);
        check("tx_te", te, 1'b1);
        bus_write(16'h0013, 8'hA5);
        peek(16'h0011, v, e);
        check("tx_tdre_pending", v, 8'h00);
        check("tx_idle_before", tx, 1'b1);
        step();
        peek(16'h0011, v, e);
        check("tx_tdre_at_start", v, 8'h20);
        frame = 10'b1_1010_0101_0;   // stop, data MSB..LSB, start
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int c = 0; c < c_DIV; c++) begin
                if (tx !== frame[k]) bad++;
                step();
            end
            check($sformatf("tx_slot%0d_bad_cycles", k), bad, 0);
        end
        check("tx_idle_after", tx, 1'b1);

        // ---- RX frame and held read ----
        do_reset();
        bus_write(16'h0010, 8'h04);
        send_rx(8'h3C, 1'b1);
        peek(16'h0011, v, e);
        check("rx_status_one", v, 8'hA1);
        bus_read(16'h0012, 3, v);
        check("rx_rdr", v, 8'h3C);
        peek(16'h0011, v, e);
        check("rx_status_empty", v, 8'h20);
        peek(16'h0012, v, e);
        check("rx_rdr_empty", v, 8'h00);

        // ---- overrun ----
        do_reset();
        bus_write(16'h0010, 8'h04);
        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
        peek(16'h0011, v, e);
        check("ovr_status_full", v, 8'hE4);
        bus_read(16'h0012, 2, v);
        check("ovr_rd1", v, 8'h01);
        peek(16'h0011, v, e);
        check("ovr_status_3", v, 8'hE3);
        bus_read(16'h0012, 1, v);
        check("ovr_rd2", v, 8'h02);
        peek(16'h0011, v, e);
        check("ovr_orfe_sticky", v, 8'hE2);
        bus_read(16'h0011, 1, v);
        check("ovr_status_read", v, 8'hE2);
        bus_read(16'h0012, 1, v);
        check("ovr_rd3", v, 8'h03);
        peek(16'h0011, v, e);
        check("ovr_orfe_cleared", v, 8'hA1);
        bus_read(16'h0012, 1, v);
        check("ovr_rd4", v, 8'h04);
        peek(16'h0011, v, e);
        check("ovr_status_end", v, 8'h20);

        // ---- false start and framing error ----
        do_reset();
        bus_write(16'h0010, 8'h04);
        rx = 1'b0;
        repeat (4) step();
        rx = 1'b1;
        repeat (40) step();
        peek(16'h0011, v, e);
        check("false_start_status", v, 8'h20);
        send_rx(8'h55, 1'b0);
        peek(16'h0011, v, e);
        check("fe_status", v, 8'hB1);
        bus_read(16'h0012, 1, v);
        check("fe_rdr", v, 8'h55);

        // ---- interrupt threshold ----
        do_reset();
        bus_write(16'h0010, 8'h0C);
        send_rx(8'h11, 1'b1);
        check("irq_below_level", irq2, 1'b0);
        found = 1'b0;
        fork
            send_rx(8'h22, 1'b1);
            begin
                for (int i = 0; i < 200 && !found; i++) begin
                    step();
                    peek(16'h0011, v, e);
                    if (v[3:0] == 4'd2) begin
                        found = 1'b1;
                        check("irq_same_cycle_as_push", irq2, 1'b0);
                        step();
                        check("irq_after_push", irq2, 1'b1);
                    end
                end
            end
        join
        check("irq_push_seen", found, 1'b1);
        bus_write(16'h0010, 8'h00);
        step();
        check("irq_disabled", irq2, 1'b0);
        bus_write(16'h0010, 8'h02);
        step();
        check("irq_tie_tdre", irq2, 1'b1);

        // ---- reset during TX data ----
        do_reset();
        bus_write(16'h0010, 8'h01);
        bus_write(16'h0013, 8'h00);
        repeat (1 + c_DIV + 8) step();
        check("mid_tx_data_low", tx, 1'b0);
        rst_n = 1'b0;
        step();
        check("mid_tx_reset_tx", tx, 1'b1);
        check("mid_tx_reset_te", te, 1'b0);
        peek(16'h0011, v, e);
        check("mid_tx_reset_status", v, 8'h20);
        peek(16'h0010, v, e);
        check("mid_tx_reset_ctrl", v, 8'h00);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (tx !== 1'b1) bad++;
        end
        check("mid_tx_no_resume", bad, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
`default_nettype wire
